// File: rtl/axi_pkt_arbiter_pkg.sv
// Shared definitions for the packet arbiter: FSM encoding, mask register
// width and the width of a port index.
package axi_pkt_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } arb_state_t;

    localparam int MASK_W = 16;
    localparam int IDX_W  = 4;

    localparam logic [MASK_W-1:0] MASK_RST = 16'hFFFF;

endpackage

// File: rtl/axi_pkt_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after i_last,
// wrapping around modulo NUM_INPUTS.
module rr_pick
    import axi_pkt_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 4
) (
    input  logic [NUM_INPUTS-1:0] i_req,
    input  logic [IDX_W-1:0]      i_last,
    output logic [IDX_W-1:0]      o_grant,
    output logic                  o_valid
);

    logic [IDX_W-1:0] w_wrap_idx;
    logic [IDX_W-1:0] w_up_idx;
    logic             w_up_hit;

    // Scan high to low so the lowest matching index is the one left standing.
    always_comb begin
        w_wrap_idx = {IDX_W{1'b0}};
        w_up_idx   = {IDX_W{1'b0}};
        w_up_hit   = 1'b0;
        for (int j = NUM_INPUTS - 1; j >= 0; j--) begin
            w_wrap_idx = i_req[j] ? IDX_W'(j) : w_wrap_idx;
            w_up_idx   = (i_req[j] && (IDX_W'(j) > i_last)) ? IDX_W'(j) : w_up_idx;
            w_up_hit   = w_up_hit | (i_req[j] && (IDX_W'(j) > i_last));
        end
    end

    assign o_grant = w_up_hit ? w_up_idx : w_wrap_idx;
    assign o_valid = |i_req;

endmodule

// File: rtl/axi_pkt_arbiter.sv
// Packet-granular round-robin merge of NUM_INPUTS AXI-Stream inputs onto one
// output; a grant is held from arbitration until the tlast beat is accepted.
module axi_pkt_arbiter
    import axi_pkt_arbiter_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int NUM_INPUTS = 4,
    parameter int SR_MASK    = 0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic                        set_stb,
    input  logic [15:0]                 set_addr,
    input  logic [31:0]                 set_data,
    input  logic [NUM_INPUTS*WIDTH-1:0] i_tdata,
    input  logic [NUM_INPUTS-1:0]       i_tvalid,
    input  logic [NUM_INPUTS-1:0]       i_tlast,
    output logic [NUM_INPUTS-1:0]       i_tready,
    input  logic [NUM_INPUTS-1:0]       pkt_present,
    output logic [WIDTH-1:0]            o_tdata,
    output logic                        o_tvalid,
    output logic                        o_tlast,
    input  logic                        o_tready,
    output logic                        busy,
    output logic [3:0]                  cur_port
);

    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_INPUTS - 1);
    localparam logic [15:0]      MASK_ADDR = 16'(SR_MASK);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [IDX_W-1:0]  r_grant;
    logic [IDX_W-1:0]  w_grant_nxt;
    logic [IDX_W-1:0]  r_last;
    logic [IDX_W-1:0]  w_last_nxt;
    logic [MASK_W-1:0] r_mask;

    logic [NUM_INPUTS-1:0] w_elig;
    logic [IDX_W-1:0]      w_pick;
    logic                  w_pick_valid;
    logic [WIDTH-1:0]      w_sel_data;
    logic                  w_sel_valid;
    logic                  w_sel_last;
    logic                  w_beat_last;
    logic                  w_mask_wr;
    logic                  w_unused;

    // i_tvalid deliberately plays no part in eligibility.
    assign w_elig    = pkt_present & r_mask[NUM_INPUTS-1:0];
    assign w_mask_wr = set_stb && (set_addr == MASK_ADDR);
    assign w_unused  = ^{set_data[31:MASK_W], r_mask};

    rr_pick #(
        .NUM_INPUTS (NUM_INPUTS)
    ) u_rr_pick (
        .i_req   (w_elig),
        .i_last  (r_last),
        .o_grant (w_pick),
        .o_valid (w_pick_valid)
    );

    // Select the granted input's data, valid and last.
    always_comb begin
        w_sel_data  = {WIDTH{1'b0}};
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        for (int n = 0; n < NUM_INPUTS; n++) begin
            w_sel_data  = (r_grant == IDX_W'(n)) ? i_tdata[n*WIDTH +: WIDTH] : w_sel_data;
            w_sel_valid = (r_grant == IDX_W'(n)) ? i_tvalid[n] : w_sel_valid;
            w_sel_last  = (r_grant == IDX_W'(n)) ? i_tlast[n] : w_sel_last;
        end
    end

    // Output stream, per-input ready and status; only the granted path is open.
    always_comb begin
        o_tdata  = {WIDTH{1'b0}};
        o_tvalid = 1'b0;
        o_tlast  = 1'b0;
        i_tready = {NUM_INPUTS{1'b0}};
        busy     = 1'b0;
        cur_port = r_last;
        if (r_state == ST_ACTIVE) begin
            o_tdata  = w_sel_data;
            o_tvalid = w_sel_valid;
            o_tlast  = w_sel_last;
            busy     = 1'b1;
            cur_port = r_grant;
            for (int n = 0; n < NUM_INPUTS; n++) begin
                i_tready[n] = (r_grant == IDX_W'(n)) & o_tready;
            end
        end else begin
            busy     = 1'b0;
            cur_port = r_last;
        end
    end

    assign w_beat_last = o_tvalid & o_tready & o_tlast;

    // Next-state logic: arbitrate in IDLE, release on the accepted tlast beat.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ST_ACTIVE;
                    w_grant_nxt = w_pick;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (w_beat_last) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = r_grant;
                end else begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Soft clear truncates any packet in flight; the mask survives.
        if (clear) begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = r_grant;
            w_last_nxt  = LAST_RST;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    // State, grant, last-winner and enable-mask registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_grant <= {IDX_W{1'b0}};
            r_last  <= LAST_RST;
            r_mask  <= MASK_RST;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
            if (w_mask_wr) begin
                r_mask <= set_data[MASK_W-1:0];
            end
        end
    end

endmodule
